fsab_arbiter_fifo: RTL and testbench

- Per-device ingress buffer for the FSAB request arbiter.
- Accepts FSAB requests (reads and multi-beat writes) from one device and stores them whole.
- Signals the arbiter when at least one complete transaction is buffered.
- After a one-cycle start pulse from the arbiter, replays exactly one transaction on its output bus, then returns one credit to the device.

---
 rtl/fsab_arbiter_fifo.sv | 193 +++++++++++++++++++
 tb/tb_fsab_arbiter_fifo.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsab_arbiter_fifo.sv
// Per-device FSAB ingress buffer: stores whole requests, flags the arbiter when one is
// complete, and replays exactly one transaction per start pulse before returning a credit.
module fsab_arbiter_fifo #(
  parameter int MYINDEX = 0,
  parameter int REQ_W   = 1,
  parameter int DID_W   = 4,
  parameter int ADDR_W  = 31,
  parameter int LEN_W   = 4,
  parameter int DATA_W  = 64,
  parameter int MASK_W  = 8,
  parameter int CREDITS = 4,
  parameter int MAX_LEN = 8
) (
  input  logic              clk,
  input  logic              Nrst,
  input  logic              inp_valid,
  input  logic [REQ_W-1:0]  inp_mode,
  input  logic [DID_W-1:0]  inp_did,
  input  logic [DID_W-1:0]  inp_subdid,
  input  logic [ADDR_W-1:0] inp_addr,
  input  logic [LEN_W-1:0]  inp_len,
  input  logic [DATA_W-1:0] inp_data,
  input  logic [MASK_W-1:0] inp_mask,
  output logic              inp_credit,
  input  logic              start_trans,
  output logic              empty_b,
  output logic              active,
  output logic              out_valid,
  output logic [REQ_W-1:0]  out_mode,
  output logic [DID_W-1:0]  out_did,
  output logic [DID_W-1:0]  out_subdid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [LEN_W-1:0]  out_len,
  output logic [DATA_W-1:0] out_data,
  output logic [MASK_W-1:0] out_mask
);
  localparam int DDEPTH = CREDITS * MAX_LEN;
  localparam int HPW    = (CREDITS > 1) ? $clog2(CREDITS) : 1;
  localparam int DPW    = (DDEPTH > 1) ? $clog2(DDEPTH) : 1;
  localparam int HCW    = $clog2(CREDITS + 1);
  localparam int DCW    = $clog2(DDEPTH + 1);
  localparam int BW     = $clog2(MAX_LEN + 1);
  localparam int HDR_W  = REQ_W + 2 * DID_W + ADDR_W + LEN_W;
  localparam int BEAT_W = DATA_W + MASK_W;

  if (MYINDEX < 0) begin : g_index_check
    $error("fsab_arbiter_fifo: MYINDEX must be non-negative");
  end

  typedef enum logic {S_IDLE, S_REPLAY} state_t;

  // Reads are one beat; write length 0 means one beat and is clamped to MAX_LEN.
  function automatic logic [BW-1:0] beats_of(input logic [REQ_W-1:0] mode,
                                             input logic [LEN_W-1:0] len);
    if (mode == '0 || len == '0) return BW'(1);
    if (32'(len) > MAX_LEN) return BW'(MAX_LEN);
    return BW'(len);
  endfunction

  function automatic logic [HPW-1:0] hinc(input logic [HPW-1:0] p);
    return (32'(p) == CREDITS - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [DPW-1:0] dinc(input logic [DPW-1:0] p);
    return (32'(p) == DDEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  logic [HDR_W-1:0]  hq [CREDITS];
  logic [BEAT_W-1:0] dq [DDEPTH];
  logic [HPW-1:0]    hwr, hrd;
  logic [DPW-1:0]    dwr, drd;
  logic [HCW-1:0]    hcnt, ccnt, ccnt_nxt;
  logic [DCW-1:0]    dcnt;
  logic [BW-1:0]     rem, left, in_beats, head_beats;
  logic              drop;
  state_t            state, state_nxt;
  logic              hdr_beat, cont_beat, hq_push, dq_push, complete;
  logic              accept_start, pop_data, pop_hdr;
  logic [HDR_W-1:0]  head_hdr;
  logic [BEAT_W-1:0] head_beat;

  assign head_hdr   = hq[hrd];
  assign head_beat  = dq[drd];
  assign head_beats = beats_of(head_hdr[HDR_W-1 -: REQ_W], head_hdr[LEN_W-1:0]);
  assign active     = (state == S_REPLAY);

  // A header arriving while the header queue is full drops the whole transaction;
  // its remaining beats are still counted off so the framing stays in step.
  always_comb begin
    hdr_beat  = inp_valid && (rem == '0);
    cont_beat = inp_valid && (rem != '0);
    in_beats  = beats_of(inp_mode, inp_len);
    hq_push   = hdr_beat && (hcnt != HCW'(CREDITS));
    dq_push   = (hq_push || (cont_beat && !drop)) && (dcnt != DCW'(DDEPTH));
    complete  = (hq_push && in_beats == BW'(1)) ||
                (cont_beat && !drop && rem == BW'(1));
  end

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    pop_data     = 1'b0;
    pop_hdr      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_trans && empty_b) begin
          accept_start = 1'b1;
          pop_data     = 1'b1;
          state_nxt    = S_REPLAY;
        end
      end
      S_REPLAY: begin
        if (left > BW'(1)) begin
          pop_data = 1'b1;
        end else begin
          pop_hdr   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ccnt_nxt = ccnt + HCW'(complete) - HCW'(accept_start);

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      hwr        <= '0;
      hrd        <= '0;
      dwr        <= '0;
      drd        <= '0;
      hcnt       <= '0;
      dcnt       <= '0;
      ccnt       <= '0;
      rem        <= '0;
      drop       <= 1'b0;
      left       <= '0;
      empty_b    <= 1'b0;
      inp_credit <= 1'b0;
    end else begin
      if (hq_push)  hwr <= hinc(hwr);
      if (pop_hdr)  hrd <= hinc(hrd);
      if (dq_push)  dwr <= dinc(dwr);
      if (pop_data) drd <= dinc(drd);
      hcnt       <= hcnt + HCW'(hq_push) - HCW'(pop_hdr);
      dcnt       <= dcnt + DCW'(dq_push) - DCW'(pop_data);
      ccnt       <= ccnt_nxt;
      empty_b    <= (ccnt_nxt != '0);
      inp_credit <= pop_hdr;
      if (hdr_beat) begin
        rem  <= in_beats - BW'(1);
        drop <= !hq_push;
      end else if (cont_beat) begin
        rem <= rem - BW'(1);
      end
      if (accept_start)  left <= head_beats;
      else if (pop_data) left <= left - BW'(1);
    end
  end

  // Queue storage carries no reset; occupancy is tracked by the counters above.
  always_ff @(posedge clk) begin
    if (hq_push) hq[hwr] <= {inp_mode, inp_did, inp_subdid, inp_addr, inp_len};
    if (dq_push) dq[dwr] <= {inp_data, inp_mask};
  end

  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      out_valid  <= 1'b0;
      out_mode   <= '0;
      out_did    <= '0;
      out_subdid <= '0;
      out_addr   <= '0;
      out_len    <= '0;
      out_data   <= '0;
      out_mask   <= '0;
    end else begin
      if (accept_start) begin
        out_valid <= 1'b1;
        {out_mode, out_did, out_subdid, out_addr, out_len} <= head_hdr;
      end else if (pop_hdr) begin
        out_valid <= 1'b0;
      end
      if (pop_data) {out_data, out_mask} <= head_beat;
    end
  end

endmodule

// File: tb/tb_fsab_arbiter_fifo.sv
// Bench for fsab_arbiter_fifo: directed vector table, hand-written corner sequences and
// a randomized device/arbiter checked against a transaction-level reference model.
module tb_fsab_arbiter_fifo;
  localparam int CREDITS = 4;
  localparam int MAX_LEN = 8;

  logic        clk = 1'b0;
  logic        Nrst;
  logic        inp_valid;
  logic [0:0]  inp_mode;
  logic [3:0]  inp_did, inp_subdid, inp_len;
  logic [30:0] inp_addr;
  logic [63:0] inp_data;
  logic [7:0]  inp_mask;
  logic        inp_credit, start_trans, empty_b, active, out_valid;
  logic [0:0]  out_mode;
  logic [3:0]  out_did, out_subdid, out_len;
  logic [30:0] out_addr;
  logic [63:0] out_data;
  logic [7:0]  out_mask;

  fsab_arbiter_fifo #(.MYINDEX(1)) dut (
    .clk(clk), .Nrst(Nrst),
    .inp_valid(inp_valid), .inp_mode(inp_mode), .inp_did(inp_did), .inp_subdid(inp_subdid),
    .inp_addr(inp_addr), .inp_len(inp_len), .inp_data(inp_data), .inp_mask(inp_mask),
    .inp_credit(inp_credit), .start_trans(start_trans), .empty_b(empty_b), .active(active),
    .out_valid(out_valid), .out_mode(out_mode), .out_did(out_did), .out_subdid(out_subdid),
    .out_addr(out_addr), .out_len(out_len), .out_data(out_data), .out_mask(out_mask)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_credit = 0;

  // Reference model: completed-transaction list plus a flat list of buffered beats.
  typedef struct packed {
    logic [0:0]  mode;
    logic [3:0]  did;
    logic [3:0]  subdid;
    logic [30:0] addr;
    logic [3:0]  len;
  } hdr_t;

  hdr_t        m_done[$];
  logic [71:0] m_beats[$];
  hdr_t        m_pend, m_cur, e_hdr;
  int          m_need, m_n, m_k;
  bit          m_drop;
  bit          e_eb, e_act, e_v, e_cr;
  logic [71:0] e_beat;

  function automatic int n_of(input logic [0:0] mode, input logic [3:0] len);
    if (mode == 1'b0 || len == 4'd0) return 1;
    if (len > MAX_LEN) return MAX_LEN;
    return int'(len);
  endfunction

  task automatic model_reset();
    m_done.delete();
    m_beats.delete();
    m_need = 0; m_drop = 0; m_n = 0; m_k = 0;
    e_eb = 0; e_act = 0; e_v = 0; e_cr = 0;
    e_hdr = '0; m_pend = '0; m_cur = '0; e_beat = '0;
  endtask

  task automatic model_step();
    bit ok;
    int held;
    hdr_t h;
    if (!Nrst) begin
      model_reset();
      return;
    end
    held = m_done.size() + ((m_need > 0 && !m_drop) ? 1 : 0) + (e_act ? 1 : 0);
    ok = start_trans && e_eb && !e_act;
    e_cr = 0;
    if (ok) begin
      m_cur = m_done.pop_front();
      m_n = n_of(m_cur.mode, m_cur.len);
      m_k = 0;
      e_act = 1; e_v = 1; e_hdr = m_cur;
      e_beat = m_beats.pop_front();
    end else if (e_act) begin
      m_k++;
      if (m_k < m_n) e_beat = m_beats.pop_front();
      else begin e_act = 0; e_v = 0; e_cr = 1; end
    end
    if (inp_valid) begin
      if (m_need == 0) begin
        h.mode = inp_mode; h.did = inp_did; h.subdid = inp_subdid;
        h.addr = inp_addr; h.len = inp_len;
        m_drop = (held >= CREDITS);
        m_pend = h;
        m_need = n_of(h.mode, h.len) - 1;
        if (!m_drop) begin
          m_beats.push_back({inp_data, inp_mask});
          if (m_need == 0) m_done.push_back(h);
        end
      end else begin
        m_need--;
        if (!m_drop) begin
          m_beats.push_back({inp_data, inp_mask});
          if (m_need == 0) m_done.push_back(m_pend);
        end
      end
    end
    e_eb = (m_done.size() != 0);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic check_all();
    check("empty_b", 64'(empty_b), 64'(e_eb));
    check("active", 64'(active), 64'(e_act));
    check("out_valid", 64'(out_valid), 64'(e_v));
    check("inp_credit", 64'(inp_credit), 64'(e_cr));
    if (e_v) begin
      check("out_data", out_data, e_beat[71:8]);
      check("out_mask", 64'(out_mask), 64'(e_beat[7:0]));
      check("out_addr", 64'(out_addr), 64'(e_hdr.addr));
      check("out_did", 64'(out_did), 64'(e_hdr.did));
      check("out_subdid", 64'(out_subdid), 64'(e_hdr.subdid));
      check("out_mode", 64'(out_mode), 64'(e_hdr.mode));
      check("out_len", 64'(out_len), 64'(e_hdr.len));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    check_all();
    if (inp_credit) n_credit++;
  endtask

  task automatic idle_in();
    inp_valid = 0; inp_mode = '0; inp_did = '0; inp_subdid = '0; inp_addr = '0;
    inp_len = '0; inp_data = '0; inp_mask = '0; start_trans = 0;
  endtask

  task automatic beat(input logic [0:0] mode, input logic [3:0] did, input logic [30:0] addr,
                      input logic [3:0] len, input logic [63:0] data);
    inp_valid = 1; inp_mode = mode; inp_did = did; inp_subdid = did ^ 4'h5;
    inp_addr = addr; inp_len = len; inp_data = data; inp_mask = data[7:0] ^ 8'h5A;
  endtask

  // Continuation beats carry junk header fields that must be ignored.
  task automatic send_txn(input logic [0:0] mode, input logic [3:0] did, input logic [30:0] addr,
                          input logic [3:0] len, input logic [63:0] base);
    int n;
    n = n_of(mode, len);
    for (int i = 0; i < n; i++) begin
      if (i == 0) beat(mode, did, addr, len, base);
      else        beat(1'b0, 4'hE, 31'h0DEAD, 4'd0, base + 64'(i));
      tick();
    end
    inp_valid = 0;
  endtask

  task automatic wait_inactive(input string name);
    int i;
    i = 0;
    while (active && i < 20) begin
      tick();
      i++;
    end
    total++;
    if (active) begin
      bad++;
      $display("FAIL %s: active=%0d after %0d cycles, want 0", name, active, i);
    end
  endtask

  task automatic start_pulse();
    start_trans = 1;
    tick();
    start_trans = 0;
  endtask

  typedef struct packed {
    logic        v;
    logic [0:0]  mode;
    logic [3:0]  did;
    logic [30:0] addr;
    logic [3:0]  len;
    logic [63:0] data;
    logic        st;
    logic [3:0]  x;      // {empty_b, active, out_valid, inp_credit}
    logic [63:0] x_data;
    logic [30:0] x_addr;
  } vec_t;

  vec_t vec [17];

  function automatic vec_t mk(input logic v, input logic [0:0] mode, input logic [3:0] did,
                              input logic [30:0] addr, input logic [3:0] len, input logic [63:0] data,
                              input logic st, input logic [3:0] x, input logic [63:0] xd,
                              input logic [30:0] xa);
    vec_t r;
    r.v = v; r.mode = mode; r.did = did; r.addr = addr; r.len = len; r.data = data;
    r.st = st; r.x = x; r.x_data = xd; r.x_addr = xa;
    return r;
  endfunction

  function automatic vec_t quiet(input logic st, input logic [3:0] x, input logic [63:0] xd,
                                 input logic [30:0] xa);
    return mk(1'b0, 1'b0, 4'd0, 31'd0, 4'd0, 64'd0, st, x, xd, xa);
  endfunction

  int d_need, d_cred;

  initial begin
    idle_in();
    Nrst = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset.empty_b", 64'(empty_b), 64'd0);
    check("reset.active", 64'(active), 64'd0);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.inp_credit", 64'(inp_credit), 64'd0);
    check("reset.out_data", out_data, 64'd0);
    check("reset.out_addr", 64'(out_addr), 64'd0);
    Nrst = 1;

    // Read, then a 4-beat write with a gap, then a start on an empty FIFO.
    vec[0]  = mk(1'b1, 1'b0, 4'd2, 31'h100, 4'd0, 64'hAA, 1'b0, 4'b1000, 64'd0, 31'd0);
    vec[1]  = quiet(1'b1, 4'b0110, 64'hAA, 31'h100);
    vec[2]  = quiet(1'b0, 4'b0001, 64'd0, 31'd0);
    vec[3]  = quiet(1'b0, 4'b0000, 64'd0, 31'd0);
    vec[4]  = mk(1'b1, 1'b1, 4'd3, 31'h200, 4'd4, 64'd0, 1'b0, 4'b0000, 64'd0, 31'd0);
    vec[5]  = mk(1'b1, 1'b0, 4'hF, 31'h3FF, 4'd0, 64'd1, 1'b0, 4'b0000, 64'd0, 31'd0);
    vec[6]  = quiet(1'b0, 4'b0000, 64'd0, 31'd0);
    vec[7]  = mk(1'b1, 1'b0, 4'hF, 31'h3FF, 4'd0, 64'd2, 1'b0, 4'b0000, 64'd0, 31'd0);
    vec[8]  = mk(1'b1, 1'b0, 4'hF, 31'h3FF, 4'd0, 64'd3, 1'b0, 4'b1000, 64'd0, 31'd0);
    vec[9]  = quiet(1'b1, 4'b0110, 64'd0, 31'h200);
    vec[10] = quiet(1'b0, 4'b0110, 64'd1, 31'h200);
    vec[11] = quiet(1'b0, 4'b0110, 64'd2, 31'h200);
    vec[12] = quiet(1'b0, 4'b0110, 64'd3, 31'h200);
    vec[13] = quiet(1'b0, 4'b0001, 64'd0, 31'd0);
    vec[14] = quiet(1'b0, 4'b0000, 64'd0, 31'd0);
    vec[15] = quiet(1'b1, 4'b0000, 64'd0, 31'd0);
    vec[16] = quiet(1'b0, 4'b0000, 64'd0, 31'd0);
    for (int i = 0; i < 17; i++) begin
      inp_valid = vec[i].v; inp_mode = vec[i].mode; inp_did = vec[i].did;
      inp_subdid = vec[i].did ^ 4'h5; inp_addr = vec[i].addr; inp_len = vec[i].len;
      inp_data = vec[i].data; inp_mask = vec[i].data[7:0] ^ 8'h5A; start_trans = vec[i].st;
      tick();
      check($sformatf("vec%0d.empty_b", i), 64'(empty_b), 64'(vec[i].x[3]));
      check($sformatf("vec%0d.active", i), 64'(active), 64'(vec[i].x[2]));
      check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vec[i].x[1]));
      check($sformatf("vec%0d.inp_credit", i), 64'(inp_credit), 64'(vec[i].x[0]));
      if (vec[i].x[1]) begin
        check($sformatf("vec%0d.out_data", i), out_data, vec[i].x_data);
        check($sformatf("vec%0d.out_addr", i), 64'(out_addr), 64'(vec[i].x_addr));
      end
    end
    idle_in();

    // Fill all credits (len 0 and len 9 boundaries), a fifth header is dropped.
    send_txn(1'b0, 4'd1, 31'h1000, 4'd0, 64'h1100);
    send_txn(1'b1, 4'd2, 31'h2000, 4'd2, 64'h2200);
    send_txn(1'b1, 4'd3, 31'h3000, 4'd0, 64'h3300);
    send_txn(1'b1, 4'd4, 31'h4000, 4'd9, 64'h4400);
    send_txn(1'b0, 4'd5, 31'h5000, 4'd0, 64'h5500);
    tick();
    n_credit = 0;
    for (int t = 0; t < 4; t++) begin
      start_pulse();
      if (t == 0 || t == 3) start_pulse();
      wait_inactive("queued.drain");
    end
    repeat (2) tick();
    check("queued.credits", 64'(n_credit), 64'd4);
    check("queued.empty_b", 64'(empty_b), 64'd0);

    // A write arrives while a read replays; starts during replay are ignored.
    send_txn(1'b0, 4'd6, 31'h6000, 4'd0, 64'h6600);
    start_trans = 1;
    send_txn(1'b1, 4'd7, 31'h7000, 4'd3, 64'h7700);
    start_trans = 0;
    tick();
    start_pulse();
    wait_inactive("overlap.drain");
    tick();

    // Reset in the middle of a replay.
    send_txn(1'b1, 4'd8, 31'h8000, 4'd4, 64'h8800);
    start_pulse();
    tick();
    Nrst = 0;
    #1;
    check("midrst.active", 64'(active), 64'd0);
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.inp_credit", 64'(inp_credit), 64'd0);
    check("midrst.out_data", out_data, 64'd0);
    check("midrst.out_addr", 64'(out_addr), 64'd0);
    check("midrst.out_did", 64'(out_did), 64'd0);
    model_reset();
    repeat (2) tick();
    Nrst = 1;
    n_credit = 0;
    repeat (3) tick();
    check("midrst.no_credit", 64'(n_credit), 64'd0);
    send_txn(1'b0, 4'd9, 31'h9000, 4'd0, 64'h9900);
    start_pulse();
    wait_inactive("midrst.fresh");
    tick();

    // Randomized device traffic that respects credits, with random start pulses.
    d_need = 0;
    d_cred = CREDITS - m_done.size() - (e_act ? 1 : 0);
    repeat (1500) begin
      idle_in();
      if (d_need > 0) begin
        if ($urandom_range(0, 3) != 0) begin
          beat(1'($urandom_range(0, 1)), 4'($urandom), 31'($urandom), 4'($urandom),
               {$urandom, $urandom});
          d_need--;
        end
      end else if (d_cred > 0 && $urandom_range(0, 2) == 0) begin
        beat(1'($urandom_range(0, 1)), 4'($urandom), 31'($urandom), 4'($urandom_range(0, 15)),
             {$urandom, $urandom});
        d_need = n_of(inp_mode, inp_len) - 1;
        d_cred--;
      end
      start_trans = ($urandom_range(0, 2) == 0);
      tick();
      if (e_cr) d_cred++;
    end
    idle_in();
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
